// File: rtl/cfg_burst_sequencer.sv
// Burst sequencer for the single-write configuration bus: range-checks one burst
// command, then issues one registered config write per accepted data word.
module cfg_burst_sequencer #(
   parameter int DEPTH_M0 = 4,
   parameter int DEPTH_M1 = 4,
   parameter int DEPTH_M2 = 64,
   parameter int DEPTH_M3 = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_sel_module,
   input  logic [7:0]  cmd_sram_sel,
   input  logic [6:0]  cmd_start_addr,
   input  logic [6:0]  cmd_len,
   input  logic        abort,
   input  logic        dat_valid,
   output logic        dat_ready,
   input  logic [63:0] dat,
   output logic [1:0]  o_cfg_sel_module,
   output logic [7:0]  o_cfg_sram_sel,
   output logic [6:0]  o_cfg_addr_write,
   output logic        o_cfg_wr_en,
   output logic [63:0] o_cfg_data,
   output logic        busy,
   output logic        done,
   output logic        cmd_err,
   output logic        aborted
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam logic [7:0] DEPTH0 = 8'(DEPTH_M0);
   localparam logic [7:0] DEPTH1 = 8'(DEPTH_M1);
   localparam logic [7:0] DEPTH2 = 8'(DEPTH_M2);
   localparam logic [7:0] DEPTH3 = 8'(DEPTH_M3);

   state_t      state_q, state_d;
   logic [1:0]  mod_q, mod_d;
   logic [7:0]  sram_q, sram_d;
   logic [6:0]  cur_addr_q, cur_addr_d;
   logic [7:0]  remaining_q, remaining_d;

   logic [1:0]  sel_out_q, sel_out_d;
   logic [7:0]  sram_out_q, sram_out_d;
   logic [6:0]  addr_out_q, addr_out_d;
   logic        wr_en_q, wr_en_d;
   logic [63:0] data_out_q, data_out_d;
   logic        done_q, done_d;
   logic        cmd_err_q, cmd_err_d;
   logic        aborted_q, aborted_d;

   logic [7:0]  len_s;
   logic [7:0]  end_s;
   logic [7:0]  depth_s;
   logic        range_ok_s;

   assign len_s      = {1'b0, cmd_len} + 8'd1;
   assign end_s      = {1'b0, cmd_start_addr} + len_s;
   assign range_ok_s = (end_s <= depth_s);

   always_comb begin
      case (cmd_sel_module)
         2'b00:   depth_s = DEPTH0;
         2'b01:   depth_s = DEPTH1;
         2'b10:   depth_s = DEPTH2;
         2'b11:   depth_s = DEPTH3;
         default: depth_s = 8'd0;
      endcase
   end

   // Next-state and registered-output computation; config bus defaults to all zero.
   always_comb begin
      state_d     = state_q;
      mod_d       = mod_q;
      sram_d      = sram_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      sel_out_d   = 2'd0;
      sram_out_d  = 8'd0;
      addr_out_d  = 7'd0;
      wr_en_d     = 1'b0;
      data_out_d  = 64'd0;
      done_d      = 1'b0;
      cmd_err_d   = 1'b0;
      aborted_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (range_ok_s) begin
                  mod_d       = cmd_sel_module;
                  sram_d      = cmd_sram_sel;
                  cur_addr_d  = cmd_start_addr;
                  remaining_d = len_s;
                  state_d     = BURST;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            // Abort wins over a same-cycle beat: that word is dropped unwritten.
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = IDLE;
            end else if (dat_valid) begin
               sel_out_d   = mod_q;
               sram_out_d  = sram_q;
               addr_out_d  = cur_addr_q;
               wr_en_d     = 1'b1;
               data_out_d  = (mod_q == 2'b10) ? {32'd0, dat[31:0]} : dat;
               cur_addr_d  = cur_addr_q + 7'd1;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = BURST;
               end
            end else begin
               state_d = BURST;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, burst context and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mod_q       <= 2'd0;
         sram_q      <= 8'd0;
         cur_addr_q  <= 7'd0;
         remaining_q <= 8'd0;
         sel_out_q   <= 2'd0;
         sram_out_q  <= 8'd0;
         addr_out_q  <= 7'd0;
         wr_en_q     <= 1'b0;
         data_out_q  <= 64'd0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mod_q       <= mod_d;
         sram_q      <= sram_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         sel_out_q   <= sel_out_d;
         sram_out_q  <= sram_out_d;
         addr_out_q  <= addr_out_d;
         wr_en_q     <= wr_en_d;
         data_out_q  <= data_out_d;
         done_q      <= done_d;
         cmd_err_q   <= cmd_err_d;
         aborted_q   <= aborted_d;
      end
   end

   assign cmd_ready        = (state_q == IDLE);
   assign dat_ready        = (state_q == BURST);
   assign busy             = (state_q == BURST);
   assign o_cfg_sel_module = sel_out_q;
   assign o_cfg_sram_sel   = sram_out_q;
   assign o_cfg_addr_write = addr_out_q;
   assign o_cfg_wr_en      = wr_en_q;
   assign o_cfg_data       = data_out_q;
   assign done             = done_q;
   assign cmd_err          = cmd_err_q;
   assign aborted          = aborted_q;

endmodule

// File: tb/tb_cfg_burst_sequencer.sv
// Directed self-checking bench for cfg_burst_sequencer; inputs change 1 time unit
// after the rising edge and outputs are sampled there.
module tb_cfg_burst_sequencer;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_sel_module;
   logic [7:0]  cmd_sram_sel;
   logic [6:0]  cmd_start_addr, cmd_len;
   logic        abort, dat_valid, dat_ready;
   logic [63:0] dat;
   logic [1:0]  o_cfg_sel_module;
   logic [7:0]  o_cfg_sram_sel;
   logic [6:0]  o_cfg_addr_write;
   logic        o_cfg_wr_en;
   logic [63:0] o_cfg_data;
   logic        busy, done, cmd_err, aborted;

   int checks = 0;
   int errors = 0;

   cfg_burst_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel_module(cmd_sel_module), .cmd_sram_sel(cmd_sram_sel),
      .cmd_start_addr(cmd_start_addr), .cmd_len(cmd_len),
      .abort(abort), .dat_valid(dat_valid), .dat_ready(dat_ready), .dat(dat),
      .o_cfg_sel_module(o_cfg_sel_module), .o_cfg_sram_sel(o_cfg_sram_sel),
      .o_cfg_addr_write(o_cfg_addr_write), .o_cfg_wr_en(o_cfg_wr_en),
      .o_cfg_data(o_cfg_data), .busy(busy), .done(done),
      .cmd_err(cmd_err), .aborted(aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [1:0] sel, input logic [7:0] sram,
                            input logic [6:0] start, input logic [6:0] len);
      cmd_valid      = 1'b1;
      cmd_sel_module = sel;
      cmd_sram_sel   = sram;
      cmd_start_addr = start;
      cmd_len        = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [85:0] outs;
      outs = {o_cfg_sel_module, o_cfg_sram_sel, o_cfg_addr_write, o_cfg_wr_en,
              o_cfg_data, busy, done, cmd_err, aborted};
      checks++;
      if (outs !== 86'd0 || cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: outs=%h cmd_ready=%b dat_ready=%b, want 0/1/0", outs, cmd_ready, dat_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      // Put a write on the bus, then reset asynchronously mid-cycle.
      issue_cmd(2'b11, 8'h2A, 7'd0, 7'd3);
      dat_valid = 1'b1;
      dat       = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      checks++;
      if (o_cfg_wr_en !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_write: wr_en=%b busy=%b, want 1/1", o_cfg_wr_en, busy);
      end
      #2 rst = 1'b1;
      #1;
      outs = {o_cfg_sel_module, o_cfg_sram_sel, o_cfg_addr_write, o_cfg_wr_en,
              o_cfg_data, busy, done, cmd_err, aborted};
      checks++;
      if (outs !== 86'd0 || cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: outs=%h cmd_ready=%b dat_ready=%b, want 0/1/0", outs, cmd_ready, dat_ready);
      end
      dat_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0 || aborted !== 1'b0 || o_cfg_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: done=%b aborted=%b wr_en=%b, want 0/0/0", done, aborted, o_cfg_wr_en);
      end
   endtask

   task automatic test_bf_burst;
      logic [63:0] w [4];
      w[0] = 64'h1111_2222_3333_4444;
      w[1] = 64'hAAAA_BBBB_CCCC_DDDD;
      w[2] = 64'h0123_4567_89AB_CDEF;
      w[3] = 64'hFEDC_BA98_7654_3210;
      issue_cmd(2'b11, 8'h2A, 7'h7C, 7'd3);
      checks++;
      if (busy !== 1'b1 || dat_ready !== 1'b1 || cmd_ready !== 1'b0 || cmd_err !== 1'b0) begin
         errors++;
         $display("FAIL bf_accept: busy=%b dat_ready=%b cmd_ready=%b cmd_err=%b, want 1/1/0/0",
                  busy, dat_ready, cmd_ready, cmd_err);
      end
      dat_valid = 1'b1;
      dat       = w[0];
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== 7'(8'h7C + i) || o_cfg_sel_module !== 2'b11 ||
             o_cfg_sram_sel !== 8'h2A || o_cfg_data !== w[i] || done !== (i == 3)) begin
            errors++;
            $display("FAIL bf_write%0d: wr_en=%b addr=%h sel=%b sram=%h data=%h done=%b, want 1/%h/11/2a/%h/%b",
                     i, o_cfg_wr_en, o_cfg_addr_write, o_cfg_sel_module, o_cfg_sram_sel, o_cfg_data, done,
                     7'(8'h7C + i), w[i], (i == 3));
         end
         if (i < 3) dat = w[i+1];
         else dat_valid = 1'b0;
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bf_end_state: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
      end
      tick();
      checks++;
      if (o_cfg_wr_en !== 1'b0 || done !== 1'b0 || o_cfg_addr_write !== 7'd0 || o_cfg_data !== 64'd0) begin
         errors++;
         $display("FAIL bf_after: wr_en=%b done=%b addr=%h data=%h, want all 0",
                  o_cfg_wr_en, done, o_cfg_addr_write, o_cfg_data);
      end
   endtask

   task automatic test_bv_mask;
      issue_cmd(2'b10, 8'h05, 7'd0, 7'd0);
      dat_valid = 1'b1;
      dat       = 64'hDEAD_BEEF_1234_5678;
      tick();
      dat_valid = 1'b0;
      checks++;
      if (o_cfg_wr_en !== 1'b1 || o_cfg_data !== 64'h0000_0000_1234_5678 || o_cfg_sel_module !== 2'b10 ||
          o_cfg_addr_write !== 7'd0 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bv_mask: wr_en=%b data=%h sel=%b addr=%h done=%b busy=%b, want 1/0000000012345678/10/00/1/0",
                  o_cfg_wr_en, o_cfg_data, o_cfg_sel_module, o_cfg_addr_write, done, busy);
      end
      tick();
   endtask

   task automatic test_range;
      // Over-range commands: module 00 start 3 len 2, module 10 start 60 len 5.
      issue_cmd(2'b00, 8'h01, 7'd3, 7'd1);
      checks++;
      if (cmd_err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || o_cfg_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL range_err_m0: cmd_err=%b busy=%b cmd_ready=%b wr_en=%b, want 1/0/1/0",
                  cmd_err, busy, cmd_ready, o_cfg_wr_en);
      end
      dat_valid = 1'b1;
      dat       = 64'h5555;
      tick();
      dat_valid = 1'b0;
      checks++;
      if (cmd_err !== 1'b0 || o_cfg_wr_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL range_err_pulse: cmd_err=%b wr_en=%b busy=%b, want 0/0/0", cmd_err, o_cfg_wr_en, busy);
      end
      issue_cmd(2'b10, 8'h01, 7'd60, 7'd4);
      checks++;
      if (cmd_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL range_err_m2: cmd_err=%b busy=%b, want 1/0", cmd_err, busy);
      end
      issue_cmd(2'b00, 8'h07, 7'd2, 7'd1);
      checks++;
      if (cmd_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL range_edge_accept: cmd_err=%b busy=%b, want 0/1", cmd_err, busy);
      end
      dat_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dat = 64'h100 + 64'(i);
         tick();
         checks++;
         if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== 7'(2 + i) || o_cfg_data !== 64'h100 + 64'(i) ||
             done !== (i == 1)) begin
            errors++;
            $display("FAIL range_edge_write%0d: wr_en=%b addr=%h data=%h done=%b, want 1/%h/%h/%b",
                     i, o_cfg_wr_en, o_cfg_addr_write, o_cfg_data, done, 7'(2 + i), 64'h100 + 64'(i), (i == 1));
         end
      end
      dat_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall;
      logic [3:0] dv_seq;
      logic [6:0] exp_addr;
      dv_seq   = 4'b1001;
      exp_addr = 7'd0;
      issue_cmd(2'b01, 8'h11, 7'd0, 7'd1);
      for (int i = 0; i < 4; i++) begin
         dat_valid = dv_seq[i];
         dat       = 64'hC0DE_0000 + 64'(i);
         tick();
         checks++;
         if (dv_seq[i]) begin
            if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== exp_addr || o_cfg_sel_module !== 2'b01 ||
                o_cfg_sram_sel !== 8'h11 || o_cfg_data !== 64'hC0DE_0000 + 64'(i) || done !== (i == 3)) begin
               errors++;
               $display("FAIL stall_write%0d: wr_en=%b addr=%h sel=%b sram=%h data=%h done=%b, want 1/%h/01/11/%h/%b",
                        i, o_cfg_wr_en, o_cfg_addr_write, o_cfg_sel_module, o_cfg_sram_sel, o_cfg_data, done,
                        exp_addr, 64'hC0DE_0000 + 64'(i), (i == 3));
            end
            exp_addr = exp_addr + 7'd1;
         end else begin
            if ({o_cfg_sel_module, o_cfg_sram_sel, o_cfg_addr_write, o_cfg_wr_en, o_cfg_data} !== 82'd0 ||
                busy !== 1'b1) begin
               errors++;
               $display("FAIL stall_gap%0d: sel=%b sram=%h addr=%h wr_en=%b data=%h busy=%b, want zeros and busy=1",
                        i, o_cfg_sel_module, o_cfg_sram_sel, o_cfg_addr_write, o_cfg_wr_en, o_cfg_data, busy);
            end
         end
      end
      dat_valid = 1'b0;
      tick();
      checks++;
      if (o_cfg_wr_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_end: wr_en=%b busy=%b, want 0/0", o_cfg_wr_en, busy);
      end
   endtask

   task automatic test_abort;
      issue_cmd(2'b11, 8'h33, 7'h10, 7'd9);
      for (int i = 0; i < 3; i++) begin
         dat_valid = 1'b1;
         dat       = 64'hAB00 + 64'(i);
         abort     = (i == 2);
         tick();
         checks++;
         if (i < 2) begin
            if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== 7'(8'h10 + i) || aborted !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL abort_write%0d: wr_en=%b addr=%h aborted=%b done=%b, want 1/%h/0/0",
                        i, o_cfg_wr_en, o_cfg_addr_write, aborted, done, 7'(8'h10 + i));
            end
         end else begin
            if (o_cfg_wr_en !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL abort_cycle: wr_en=%b aborted=%b done=%b busy=%b cmd_ready=%b, want 0/1/0/0/1",
                        o_cfg_wr_en, aborted, done, busy, cmd_ready);
            end
         end
      end
      dat_valid = 1'b0;
      // abort held while idle must not block the next command.
      issue_cmd(2'b00, 8'h44, 7'd1, 7'd0);
      abort = 1'b0;
      checks++;
      if (aborted !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_next_cmd: aborted=%b busy=%b, want 0/1", aborted, busy);
      end
      dat_valid = 1'b1;
      dat       = 64'h77;
      tick();
      dat_valid = 1'b0;
      checks++;
      if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== 7'd1 || o_cfg_sram_sel !== 8'h44 || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_next_write: wr_en=%b addr=%h sram=%h done=%b, want 1/01/44/1",
                  o_cfg_wr_en, o_cfg_addr_write, o_cfg_sram_sel, done);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      issue_cmd(2'b10, 8'h09, 7'd10, 7'd0);
      dat_valid = 1'b1;
      dat       = 64'hA;
      tick();
      // Present the next command in the same cycle that done is visible.
      dat_valid      = 1'b0;
      cmd_valid      = 1'b1;
      cmd_sel_module = 2'b10;
      cmd_sram_sel   = 8'h0A;
      cmd_start_addr = 7'd20;
      cmd_len        = 7'd0;
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1 || o_cfg_addr_write !== 7'd10) begin
         errors++;
         $display("FAIL b2b_first: done=%b cmd_ready=%b addr=%h, want 1/1/0a", done, cmd_ready, o_cfg_addr_write);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
      end
      dat_valid = 1'b1;
      dat       = 64'hB;
      tick();
      dat_valid = 1'b0;
      checks++;
      if (o_cfg_wr_en !== 1'b1 || o_cfg_addr_write !== 7'd20 || o_cfg_sram_sel !== 8'h0A || done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: wr_en=%b addr=%h sram=%h done=%b, want 1/14/0a/1",
                  o_cfg_wr_en, o_cfg_addr_write, o_cfg_sram_sel, done);
      end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      cmd_valid      = 1'b0;
      cmd_sel_module = 2'd0;
      cmd_sram_sel   = 8'd0;
      cmd_start_addr = 7'd0;
      cmd_len        = 7'd0;
      abort          = 1'b0;
      dat_valid      = 1'b0;
      dat            = 64'd0;
      #3;
      test_reset();
      test_bf_burst();
      test_bv_mask();
      test_range();
      test_stall();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cfg_burst_sequencer.md
# cfg_burst_sequencer

Burst sequencer that drives the single-write configuration bus (sel_module / sram_sel / addr_write / wr_en / data) feeding the parser's config distribution stage. It accepts one burst command (target module, SRAM select, start address, length) and then a stream of 64-bit data words, and emits one configuration write per accepted word with an auto-incrementing address. Range checking against each target's table depth happens before any write is issued, so an out-of-range burst never reaches the IBF network, IBF mux, BV or BF tables.

## Interface
Parameters:
- DEPTH_M0, 4, entries per SRAM for module 00 (IBF network)
- DEPTH_M1, 4, entries per SRAM for module 01 (IBF mux)
- DEPTH_M2, 64, entries per SRAM for module 10 (BV)
- DEPTH_M3, 128, entries per SRAM for module 11 (BF)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_sel_module  in  2  target module
- cmd_sram_sel  in  8  SRAM select, passed through unchanged
- cmd_start_addr  in  7  first write address
- cmd_len  in  7  burst length minus one (1..128 words)
- abort  in  1  synchronous burst abort
- dat_valid  in  1  data word valid
- dat_ready  out  1  sequencer can accept a data word
- dat  in  64  data word
- o_cfg_sel_module  out  2  config bus module select
- o_cfg_sram_sel  out  8  config bus SRAM select
- o_cfg_addr_write  out  7  config bus write address
- o_cfg_wr_en  out  1  config bus write strobe
- o_cfg_data  out  64  config bus data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, last write of a burst
- cmd_err  out  1  one-cycle pulse, command rejected
- aborted  out  1  one-cycle pulse, burst aborted

## Operation
- FSM states: IDLE, BURST.
- IDLE: cmd_ready=1, dat_ready=0. Handshake = cmd_valid & cmd_ready.
- On handshake, len = cmd_len+1 (8-bit). Check cmd_start_addr + len <= depth(cmd_sel_module), computed in 8 bits, no wrap.
  - Fail: cmd_err pulses next cycle. Stay IDLE. No write issued.
  - Pass: latch module, sram_sel, cur_addr=start, remaining=len. Go to BURST.
- BURST: cmd_ready=0, dat_ready=1, busy=1. Each beat (dat_valid & dat_ready) issues one write at cur_addr, then cur_addr+1 and remaining-1.
  - Module 10: o_cfg_data[63:32] forced to 0.
  - Beat with remaining==1 is the last. done pulses with its write. FSM returns to IDLE.
- abort in BURST has priority over a same-cycle beat. That beat is dropped and no write is issued. aborted pulses next cycle, FSM returns to IDLE, done is not pulsed. abort in IDLE is ignored.
- When o_cfg_wr_en=0, all o_cfg_* buses are driven to 0.
- dat_valid in IDLE is ignored. Words are never buffered.

## Timing
- Reset (async assert): state IDLE. All o_cfg_*, busy, done, cmd_err and aborted are 0. cmd_ready=1 and dat_ready=0 are combinational from state. Reset mid-burst discards the burst with no done and no aborted.
- Command handshake at cycle T: busy=1 and dat_ready=1 from T+1, or cmd_err=1 at T+1 only.
- Beat accepted at cycle N: o_cfg_wr_en=1 with the address and data at N+1 (1-cycle registered latency).
- Full-rate bursts give back-to-back writes.
- Last beat at N: done=1 at N+1, busy=0 at N+1, cmd_ready=1 at N+1. The next command can be accepted at N+1.
- abort at N: aborted=1 and busy=0 at N+1.

## Test plan
- Reset with outputs driven: assert rst asynchronously mid-cycle -> all outputs 0 immediately and cmd_ready=1.
- BF burst, module 11, sram_sel 0x2A, start 0x7C, cmd_len 3, four back-to-back words -> writes at addresses 0x7C..0x7F on consecutive cycles, done with the 0x7F write, cmd_ready high the next cycle.
- BV data masking, module 10, start 0, cmd_len 0, dat 0xDEADBEEF_12345678 -> one write with o_cfg_data=0x00000000_12345678 and done.
- Range error, module 00, start 3, cmd_len 1 (3+2>4) -> cmd_err pulse at T+1, no o_cfg_wr_en, FSM stays IDLE. Boundary pass case: start 2, cmd_len 1 -> writes at addresses 2 and 3.
- Stalled stream, module 01, cmd_len 1, dat_valid toggling 1,0,0,1 -> exactly two writes, each one cycle after its beat, with o_cfg_* = 0 in gap cycles.
- Abort, module 11, cmd_len 9, abort on the same cycle as the 3rd beat -> only 2 writes, aborted pulse, no done, next command accepted.
